// File: rtl/mult_job_sequencer.sv
// Feeds operand pairs from a small FIFO into a shift-add 8x8 multiplier one job at a time,
// collects each product with a sequence tag, and aborts jobs the multiplier never finishes.
`timescale 1ns/1ps
module mult_job_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [7:0]       In_A,
  input  logic [7:0]       In_B,
  output logic             Mul_Start,
  output logic [7:0]       Mul_Multiplicando,
  output logic [7:0]       Mul_Multiplicador,
  input  logic [16:0]      Mul_Producto,
  input  logic             Mul_Ready,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [16:0]      Out_Producto,
  output logic [TAG_W-1:0] Out_Tag,
  output logic             Out_Err,
  output logic             Busy
);

  localparam int AW  = $clog2(DEPTH);
  localparam int WDW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_CAPTURE, S_OUTPUT
  } state_t;

  state_t           state_q, state_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [15:0]      mem_q [DEPTH];
  logic [15:0]      head;
  logic [AW:0]      count;
  logic             full, empty, push, pop, timeout;
  logic [7:0]       op_a_q, op_a_d, op_b_q, op_b_d;
  logic [16:0]      prod_q, prod_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d, tag_q, tag_d;
  logic             err_q, err_d, vld_q, vld_d, ack_hi_q, ack_hi_d;
  logic [WDW-1:0]   wdog_q, wdog_d;

  // Extra pointer bit distinguishes full from empty; In_Ready depends only on registered pointers.
  assign count   = wr_ptr_q - rd_ptr_q;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push    = In_Valid && !full;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];
  assign timeout = (wdog_q == WDW'(TIMEOUT - 1));
  assign wr_ptr_d = wr_ptr_q + (AW+1)'(push);
  assign rd_ptr_d = rd_ptr_q + (AW+1)'(pop);

  always_ff @(posedge Clock) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {In_A, In_B};
  end

  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    prod_d    = prod_q;
    out_tag_d = out_tag_q;
    tag_d     = tag_q;
    err_d     = err_q;
    vld_d     = vld_q;
    wdog_d    = wdog_q;
    ack_hi_d  = ack_hi_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty && Mul_Ready) begin
          op_a_d  = head[15:8];
          op_b_d  = head[7:0];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wdog_d   = '0;
        ack_hi_d = 1'b0;
        state_d  = S_WAIT_ACK;
      end
      S_WAIT_ACK, S_WAIT_DONE: begin
        wdog_d = wdog_q + WDW'(1);
        if (state_q == S_WAIT_ACK) begin
          // Ready never dropping for two cycles means the job completed instantly.
          if (!Mul_Ready)    state_d = S_WAIT_DONE;
          else if (ack_hi_q) state_d = S_CAPTURE;
          else               ack_hi_d = 1'b1;
        end else if (Mul_Ready) begin
          state_d = S_CAPTURE;
        end
        if (timeout && state_d != S_CAPTURE) begin
          prod_d    = '0;
          err_d     = 1'b1;
          out_tag_d = tag_q;
          tag_d     = tag_q + TAG_W'(1);
          pop       = 1'b1;
          vld_d     = 1'b1;
          state_d   = S_OUTPUT;
        end
      end
      S_CAPTURE: begin
        prod_d    = Mul_Producto;
        err_d     = 1'b0;
        out_tag_d = tag_q;
        tag_d     = tag_q + TAG_W'(1);
        pop       = 1'b1;
        vld_d     = 1'b1;
        state_d   = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (Out_Ready) begin
          vld_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      prod_q    <= '0;
      out_tag_q <= '0;
      tag_q     <= '0;
      err_q     <= 1'b0;
      vld_q     <= 1'b0;
      wdog_q    <= '0;
      ack_hi_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      prod_q    <= prod_d;
      out_tag_q <= out_tag_d;
      tag_q     <= tag_d;
      err_q     <= err_d;
      vld_q     <= vld_d;
      wdog_q    <= wdog_d;
      ack_hi_q  <= ack_hi_d;
    end
  end

  assign In_Ready          = !full;
  assign Mul_Start         = (state_q == S_ISSUE);
  assign Mul_Multiplicando = op_a_q;
  assign Mul_Multiplicador = op_b_q;
  assign Out_Valid         = vld_q;
  assign Out_Producto      = prod_q;
  assign Out_Tag           = out_tag_q;
  assign Out_Err           = err_q;
  assign Busy              = (state_q != S_IDLE) || !empty;

endmodule
